// File: rtl/branch_hazard_ctrl_if.sv
// Pipeline-side bundle for the branch hazard controller: IF prediction lookup,
// EX resolution, and the flush/redirect/stall/halt controls plus perf counters.
interface branch_hazard_ctrl_if;
   logic [31:0] if_pc;
   logic [6:0]  if_opcode;
   logic        predict_taken;
   logic        ex_valid;
   logic [6:0]  ex_opcode;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic        ex_pred;
   logic [31:0] ex_target;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_stall;
   logic        halt;
   logic [31:0] branch_cnt;
   logic [31:0] mispredict_cnt;

   modport master (
      output if_pc, if_opcode, ex_valid, ex_opcode, ex_pc, ex_taken, ex_pred, ex_target,
      input  predict_taken, flush, redirect_valid, redirect_pc, fetch_stall, halt,
             branch_cnt, mispredict_cnt
   );

   modport slave (
      input  if_pc, if_opcode, ex_valid, ex_opcode, ex_pc, ex_taken, ex_pred, ex_target,
      output predict_taken, flush, redirect_valid, redirect_pc, fetch_stall, halt,
             branch_cnt, mispredict_cnt
   );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Branch predictor (16 x 2-bit counters) with mispredict flush and halt drain sequencing.
// Define BRANCH_PERF_CNT_EN to build the resolved-branch / mispredict counters.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_RUN    | normal operation, branches resolve and train the table
//   ST_FLUSH1 | first squash cycle, redirect PC loaded
//   ST_FLUSH2 | second squash cycle, EX contents ignored
//   ST_DRAIN  | halt seen, fetch frozen for two cycles
//   ST_HALTED | pipeline drained, exit only through rst
module branch_hazard_ctrl (
   input logic               clk,
   input logic               rst,
   branch_hazard_ctrl_if.slave bus
);
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_HALT   = 7'b0000000;

   typedef enum logic [2:0] {
      ST_RUN    = 3'd0,
      ST_FLUSH1 = 3'd1,
      ST_FLUSH2 = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HALTED = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        drain_cnt_q;
   logic [1:0]  bht_q [16];
   logic [31:0] redirect_pc_q;
   logic        resolved;
   logic        mispredict;
   logic        halt_seen;
   logic [3:0]  ex_idx;

   assign ex_idx     = bus.ex_pc[5:2];
   assign resolved   = (state_q == ST_RUN) && bus.ex_valid && (bus.ex_opcode == OP_BRANCH);
   assign mispredict = resolved && (bus.ex_taken != bus.ex_pred);
   assign halt_seen  = (state_q == ST_RUN) && bus.ex_valid && (bus.ex_opcode == OP_HALT);

   // Lookup reads the registered table, so an EX update to the same index is not bypassed.
   assign bus.predict_taken = (bus.if_opcode == OP_BRANCH) && bht_q[bus.if_pc[5:2]][1];

   logic unused_if_pc;
   assign unused_if_pc = ^{bus.if_pc[31:6], bus.if_pc[1:0]};

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (halt_seen)       state_d = ST_DRAIN;
            else if (mispredict) state_d = ST_FLUSH1;
         end
         ST_FLUSH1: state_d = ST_FLUSH2;
         ST_FLUSH2: state_d = ST_RUN;
         ST_DRAIN:  if (drain_cnt_q) state_d = ST_HALTED;
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_RUN;
      endcase
   end

   always_comb begin
      bus.flush          = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.fetch_stall    = 1'b0;
      bus.halt           = 1'b0;
      case (state_q)
         ST_FLUSH1: begin
            bus.flush          = 1'b1;
            bus.redirect_valid = 1'b1;
         end
         ST_FLUSH2: bus.flush = 1'b1;
         ST_DRAIN: begin
            bus.flush       = 1'b1;
            bus.fetch_stall = 1'b1;
         end
         ST_HALTED: begin
            bus.flush       = 1'b1;
            bus.fetch_stall = 1'b1;
            bus.halt        = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.redirect_pc = redirect_pc_q;

   always_ff @(posedge clk) begin
      if (rst)                     drain_cnt_q <= 1'b0;
      else if (state_q == ST_DRAIN) drain_cnt_q <= ~drain_cnt_q;
      else                         drain_cnt_q <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst)             redirect_pc_q <= 32'd0;
      else if (mispredict) redirect_pc_q <= bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) bht_q[i] <= 2'b01;
      end else if (resolved) begin
         if (bus.ex_taken && (bht_q[ex_idx] != 2'b11))
            bht_q[ex_idx] <= bht_q[ex_idx] + 2'b01;
         else if (!bus.ex_taken && (bht_q[ex_idx] != 2'b00))
            bht_q[ex_idx] <= bht_q[ex_idx] - 2'b01;
      end
   end

`ifdef BRANCH_PERF_CNT_EN
   logic [31:0] branch_cnt_q;
   logic [31:0] mispredict_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt_q     <= 32'd0;
         mispredict_cnt_q <= 32'd0;
      end else begin
         if (resolved)   branch_cnt_q     <= branch_cnt_q + 32'd1;
         if (mispredict) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
   end

   assign bus.branch_cnt     = branch_cnt_q;
   assign bus.mispredict_cnt = mispredict_cnt_q;
`else
   assign bus.branch_cnt     = 32'd0;
   assign bus.mispredict_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Scoreboard bench for branch_hazard_ctrl: expectations queued with each stimulus,
// compared after the following clock edge (or immediately for the combinational lookup).
module tb_branch_hazard_ctrl;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_HALT   = 7'b0000000;
   localparam logic [6:0] OP_ALU    = 7'b0010011;

   localparam int S_PRED  = 0;
   localparam int S_FLUSH = 1;
   localparam int S_RV    = 2;
   localparam int S_RPC   = 3;
   localparam int S_STALL = 4;
   localparam int S_HALT  = 5;
   localparam int S_BCNT  = 6;
   localparam int S_MCNT  = 7;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_hazard_ctrl_if bus ();
   branch_hazard_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   br_cnt   = 0;
   int   mp_cnt   = 0;

   function automatic logic [31:0] observe(int sel);
      case (sel)
         S_PRED:  return {31'd0, bus.predict_taken};
         S_FLUSH: return {31'd0, bus.flush};
         S_RV:    return {31'd0, bus.redirect_valid};
         S_RPC:   return bus.redirect_pc;
         S_STALL: return {31'd0, bus.fetch_stall};
         S_HALT:  return {31'd0, bus.halt};
         S_BCNT:  return bus.branch_cnt;
         S_MCNT:  return bus.mispredict_cnt;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic logic [31:0] exp_cnt(int v);
`ifdef BRANCH_PERF_CNT_EN
      return v;
`else
      return (v == v) ? 32'd0 : 32'd1;
`endif
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int sel, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_eq(e.tag, observe(e.sel), e.val);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      sb_check();
   endtask

   task automatic ex_idle();
      bus.ex_valid  = 1'b0;
      bus.ex_opcode = OP_ALU;
      bus.ex_pc     = 32'd0;
      bus.ex_taken  = 1'b0;
      bus.ex_pred   = 1'b0;
      bus.ex_target = 32'd0;
   endtask

   task automatic push_quiet(input string tag);
      push({tag, "_flush"}, S_FLUSH, 0);
      push({tag, "_rv"},    S_RV,    0);
      push({tag, "_stall"}, S_STALL, 0);
      push({tag, "_halt"},  S_HALT,  0);
   endtask

   task automatic pred_check(input string tag, input logic [31:0] pc, input logic exp);
      bus.if_pc     = pc;
      bus.if_opcode = OP_BRANCH;
      #1;
      push(tag, S_PRED, {31'd0, exp});
      sb_check();
   endtask

   // Drives one resolved branch; on a mispredict also walks the two flush cycles,
   // optionally with a live branch in EX that must not train the table.
   task automatic drive_branch(input string tag, input logic [31:0] pc, input logic taken,
                               input logic pred, input logic [31:0] target,
                               input bit noise, input int pre_pred);
      logic        mp;
      logic [31:0] rpc;
      bus.ex_valid  = 1'b1;
      bus.ex_opcode = OP_BRANCH;
      bus.ex_pc     = pc;
      bus.ex_taken  = taken;
      bus.ex_pred   = pred;
      bus.ex_target = target;
      bus.if_pc     = pc;
      bus.if_opcode = OP_BRANCH;
      if (pre_pred >= 0) begin
         #1;
         push({tag, "_collide"}, S_PRED, pre_pred);
         sb_check();
      end
      mp  = (taken != pred);
      rpc = taken ? target : pc + 32'd4;
      br_cnt++;
      if (mp) mp_cnt++;
      push({tag, "_flush"}, S_FLUSH, {31'd0, mp});
      push({tag, "_rv"},    S_RV,    {31'd0, mp});
      if (mp) push({tag, "_rpc"}, S_RPC, rpc);
      push({tag, "_bcnt"}, S_BCNT, exp_cnt(br_cnt));
      push({tag, "_mcnt"}, S_MCNT, exp_cnt(mp_cnt));
      step();
      if (mp) begin
         if (noise) begin
            bus.ex_valid  = 1'b1;
            bus.ex_opcode = OP_BRANCH;
            bus.ex_pc     = 32'h0000_0020;
            bus.ex_taken  = 1'b1;
            bus.ex_pred   = 1'b0;
            bus.ex_target = 32'h0000_0099;
         end else begin
            ex_idle();
         end
         push({tag, "_f2_flush"}, S_FLUSH, 1);
         push({tag, "_f2_rv"},    S_RV,    0);
         step();
         push({tag, "_run_flush"}, S_FLUSH, 0);
         push({tag, "_run_bcnt"},  S_BCNT,  exp_cnt(br_cnt));
         push({tag, "_run_mcnt"},  S_MCNT,  exp_cnt(mp_cnt));
         step();
      end
      ex_idle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      br_cnt = 0;
      mp_cnt = 0;
      step();
      push_quiet("rst");
      push("rst_rpc",  S_RPC,  0);
      push("rst_bcnt", S_BCNT, 0);
      push("rst_mcnt", S_MCNT, 0);
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.if_pc     = 32'd0;
      bus.if_opcode = OP_ALU;
      ex_idle();

      // Reset state and initial weakly-not-taken prediction.
      do_reset();
      pred_check("init_pred_0x10", 32'h10, 1'b0);
      bus.if_opcode = OP_ALU;
      #1;
      push("nonbranch_pred", S_PRED, 0);
      sb_check();

      // Taken branches at 0x10: first mispredicts and redirects to 0x40.
      drive_branch("b1", 32'h10, 1'b1, 1'b0, 32'h40, 1'b0, 0);
      pred_check("b1_pred", 32'h10, 1'b1);
      drive_branch("b2", 32'h10, 1'b1, 1'b1, 32'h40, 1'b0, 1);
      pred_check("b2_pred", 32'h10, 1'b1);

      // Not-taken mispredict at the top of memory wraps to 0; flush-time EX is ignored.
      drive_branch("wrap", 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234, 1'b1, -1);
      pred_check("noise_ignored", 32'h20, 1'b0);
      pred_check("wrap_pred", 32'hFFFF_FFFC, 1'b0);

      // Saturation at 0x20: four not-taken then four taken.
      for (int i = 0; i < 4; i++) begin
         drive_branch($sformatf("nt%0d", i), 32'h20, 1'b0, 1'b0, 32'h0, 1'b0, 0);
         pred_check($sformatf("nt%0d_pred", i), 32'h20, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         drive_branch($sformatf("t%0d", i), 32'h20, 1'b1, 1'b1, 32'h80, 1'b0, (i >= 2) ? 1 : 0);
         pred_check($sformatf("t%0d_pred", i), 32'h20, (i >= 1));
      end

      // Halt drain: stall next cycle, halt three cycles after the halt opcode.
      bus.ex_valid  = 1'b1;
      bus.ex_opcode = OP_HALT;
      push("drain0_stall", S_STALL, 1);
      push("drain0_flush", S_FLUSH, 1);
      push("drain0_halt",  S_HALT,  0);
      step();
      ex_idle();
      push("drain1_stall", S_STALL, 1);
      push("drain1_halt",  S_HALT,  0);
      step();
      push("halted_halt",  S_HALT,  1);
      push("halted_stall", S_STALL, 1);
      push("halted_flush", S_FLUSH, 1);
      step();
      bus.ex_valid  = 1'b1;
      bus.ex_opcode = OP_BRANCH;
      bus.ex_pc     = 32'h10;
      bus.ex_taken  = 1'b0;
      bus.ex_pred   = 1'b1;
      push("halted_stays", S_HALT, 1);
      push("halted_no_rv", S_RV,   0);
      step();
      ex_idle();

      // Reset leaves HALTED and restores counters to 01.
      do_reset();
      pred_check("post_rst_pred", 32'h10, 1'b0);

      // Five branches with two mispredicts at 0x30.
      drive_branch("p0", 32'h30, 1'b1, 1'b1, 32'h100, 1'b0, -1);
      drive_branch("p1", 32'h30, 1'b1, 1'b0, 32'h100, 1'b0, -1);
      drive_branch("p2", 32'h30, 1'b0, 1'b0, 32'h100, 1'b0, -1);
      drive_branch("p3", 32'h30, 1'b0, 1'b1, 32'h100, 1'b0, -1);
      drive_branch("p4", 32'h30, 1'b1, 1'b1, 32'h100, 1'b0, -1);
      push("perf_bcnt", S_BCNT, exp_cnt(5));
      push("perf_mcnt", S_MCNT, exp_cnt(2));
      sb_check();

      // Reset in the middle of a flush aborts it.
      bus.ex_valid  = 1'b1;
      bus.ex_opcode = OP_BRANCH;
      bus.ex_pc     = 32'h40;
      bus.ex_taken  = 1'b1;
      bus.ex_pred   = 1'b0;
      bus.ex_target = 32'h80;
      push("mid_rv",  S_RV,  1);
      push("mid_rpc", S_RPC, 32'h80);
      step();
      ex_idle();
      rst = 1'b1;
      push("abort_flush", S_FLUSH, 0);
      push("abort_rv",    S_RV,    0);
      push("abort_rpc",   S_RPC,   0);
      step();
      rst = 1'b0;
      push_quiet("after_abort");
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/branch_hazard_ctrl.md
BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 SHALL have clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have if_pc  input  32  PC of instruction in IF.
REQ-004 SHALL have if_opcode  input  7  opcode of instruction in IF.
REQ-005 SHALL have predict_taken  output  1  combinational prediction for IF instruction.
REQ-006 SHALL have ex_valid  input  1  EX holds a real (non-bubble) instruction.
REQ-007 SHALL have ex_opcode  input  7  opcode in EX.
REQ-008 SHALL have ex_pc  input  32  PC of instruction in EX.
REQ-009 SHALL have ex_taken  input  1  resolved branch outcome from EX.
REQ-010 SHALL have ex_pred  input  1  prediction carried with the EX instruction.
REQ-011 SHALL have ex_target  input  32  resolved taken target from EX.
REQ-012 SHALL have flush  output  1  squash IF/ID and ID/EX.
REQ-013 SHALL have redirect_valid  output  1  load redirect_pc into PC this cycle.
REQ-014 SHALL have redirect_pc  output  32  corrected fetch address.
REQ-015 SHALL have fetch_stall  output  1  freeze PC and IF/ID.
REQ-016 SHALL have halt  output  1  pipeline fully drained after halt opcode.
REQ-017 SHALL have branch_cnt  output  32  resolved branch count.
REQ-018 SHALL have mispredict_cnt  output  32  mispredict count.

Function
REQ-019 SHALL hold a 16-entry table of 2-bit saturating counters indexed by PC[5:2].
REQ-020 SHALL drive predict_taken = (if_opcode==7'b1100011) AND counter[if_pc[5:2]][1]; else 0.
REQ-021 SHALL treat EX instruction as resolved branch when ex_valid=1, ex_opcode==7'b1100011, state RUN.
REQ-022 SHALL, on resolved branch, update counter[ex_pc[5:2]] next edge: +1 if ex_taken (saturate 3), -1 otherwise (saturate 0).
REQ-023 SHALL, when IF and EX index collide in same cycle, return pre-update value to predict_taken (no bypass).
REQ-024 SHALL detect mispredict when resolved branch has ex_taken != ex_pred.
REQ-025 SHALL implement FSM states RUN, FLUSH1, FLUSH2, DRAIN, HALTED.
REQ-026 SHALL transition RUN->FLUSH1 on mispredict; FLUSH1->FLUSH2; FLUSH2->RUN.
REQ-027 SHALL, in FLUSH1, assert redirect_valid=1, flush=1, redirect_pc = ex_taken ? ex_target : ex_pc+4 as registered at mispredict edge (one-cycle latency).
REQ-028 SHALL, in FLUSH2, assert flush=1, redirect_valid=0; all EX inputs ignored (no counter update) in FLUSH1 and FLUSH2.
REQ-029 SHALL transition RUN->DRAIN when ex_valid=1 and ex_opcode==7'b0000000; halt takes priority if coincident with mispredict (impossible encoding, defined anyway).
REQ-030 SHALL, in DRAIN, assert fetch_stall=1 and flush=1, count 2 cycles, then enter HALTED.
REQ-031 SHALL, in HALTED, assert halt=1, fetch_stall=1, flush=1; leave only on rst.
REQ-032 SHALL wrap ex_pc+4 modulo 2^32.

Reset
REQ-033 SHALL, on rst, set all counters to 2'b01, state RUN, drain count 0.
REQ-034 SHALL, during/after reset, drive flush=0, redirect_valid=0, redirect_pc=0, fetch_stall=0, halt=0, branch_cnt=0, mispredict_cnt=0.
REQ-035 SHALL abort any FLUSH/DRAIN/HALTED sequence immediately when rst asserts mid-operation.

Configuration
REQ-036 SHALL, with BRANCH_PERF_CNT_EN defined, increment branch_cnt per resolved branch and mispredict_cnt per mispredict, wrapping at 2^32.
REQ-037 SHALL, without BRANCH_PERF_CNT_EN, tie branch_cnt and mispredict_cnt to 0 with no counter registers.

Verification
REQ-038 SHALL cover: reset, if_opcode=1100011, if_pc=0x10 -> predict_taken=0 (counter 01).
REQ-039 SHALL cover: two taken branches at pc 0x10, ex_pred=0 then 1 -> counter 11, predict_taken=1; first causes FLUSH1 with redirect_pc=ex_target=0x40.
REQ-040 SHALL cover: not-taken mispredict at ex_pc=0xFFFFFFFC, ex_pred=1 -> redirect_pc=0x00000000, flush high 2 cycles, EX inputs during flush leave counters unchanged.
REQ-041 SHALL cover: four not-taken at pc 0x20 -> counter saturates 00, no underflow; four taken -> 11, no overflow.
REQ-042 SHALL cover: ex_opcode=0000000 ex_valid=1 -> fetch_stall next cycle, halt=1 three cycles later; rst then returns halt=0.
REQ-043 SHALL cover: with BRANCH_PERF_CNT_EN, 5 branches incl. 2 mispredicts -> branch_cnt=5, mispredict_cnt=2; without macro both read 0.
